clarvi_part_sequencer: RTL and testbench

CLARVI_PART_SEQUENCER -- requirements
Module: clarvi_part_sequencer

---
 rtl/clarvi_part_sequencer.sv | 98 +++++++++
 tb/tb_clarvi_part_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clarvi_part_sequencer.sv
// Multi-part instruction sequencer: issues one DATA_W-wide part per unstalled cycle
// and forwards per-part operands from downstream stages, detecting load-use hazards.
module clarvi_part_sequencer #(
  parameter int NPARTS = 2,
  parameter int DATA_W = 32,
  parameter int NFWD   = 3,
  localparam int PART_W = (NPARTS > 2) ? $clog2(NPARTS) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic                     in_single,
  input  logic                     in_reverse,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic                     rs1_used,
  input  logic                     rs2_used,
  input  logic [DATA_W-1:0]        rf_rs1,
  input  logic [DATA_W-1:0]        rf_rs2,
  input  logic [NFWD-1:0]          fwd_valid,
  input  logic [NFWD-1:0]          fwd_is_load,
  input  logic [5*NFWD-1:0]        fwd_rd,
  input  logic [PART_W*NFWD-1:0]   fwd_part,
  input  logic [DATA_W*NFWD-1:0]   fwd_value,
  input  logic                     fwd_load_fault,
  output logic                     out_valid,
  output logic [PART_W-1:0]        part_idx,
  output logic                     part_first,
  output logic                     part_last,
  output logic                     fetch_hold,
  output logic                     load_dep_stall,
  output logic [DATA_W-1:0]        rs1_value,
  output logic [DATA_W-1:0]        rs2_value
);

  typedef logic [PART_W-1:0] part_t;

  localparam part_t LAST_MULTI = part_t'(NPARTS - 1);

  part_t cnt_q, cnt_d;
  part_t last;
  logic [NFWD-1:0] elig1, elig2;

  always_comb begin
    last       = in_single ? '0 : LAST_MULTI;
    part_idx   = (in_reverse && !in_single) ? last - cnt_q : cnt_q;
    part_first = (cnt_q == '0);
    part_last  = (cnt_q == last);
  end

  // Only the EX-stage load can be too late to forward; an address fault kills it,
  // so there is nothing to wait for.
  always_comb begin
    load_dep_stall = in_valid && fwd_valid[0] && fwd_is_load[0] && !fwd_load_fault
                  && (fwd_part[PART_W-1:0] == part_idx)
                  && ((rs1_used && rs1 == fwd_rd[4:0]) || (rs2_used && rs2 == fwd_rd[4:0]))
                  && (fwd_rd[4:0] != 5'd0);
    out_valid  = in_valid && !stall && !load_dep_stall && !flush;
    fetch_hold = in_valid && ((cnt_q != last) || load_dep_stall);
  end

  always_comb begin
    for (int s = 0; s < NFWD; s++) begin
      elig1[s] = fwd_valid[s] && (fwd_rd[5*s +: 5] == rs1) && (fwd_rd[5*s +: 5] != 5'd0)
              && (fwd_part[PART_W*s +: PART_W] == part_idx) && !(s == 0 && fwd_is_load[s]);
      elig2[s] = fwd_valid[s] && (fwd_rd[5*s +: 5] == rs2) && (fwd_rd[5*s +: 5] != 5'd0)
              && (fwd_part[PART_W*s +: PART_W] == part_idx) && !(s == 0 && fwd_is_load[s]);
    end
  end

  // Scan from oldest to youngest so the youngest eligible stage wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rs1_value = rf_rs1;
    rs2_value = rf_rs2;
    for (int s = NFWD - 1; s >= 0; s--) begin
      if (elig1[s]) rs1_value = fwd_value[DATA_W*s +: DATA_W];
      if (elig2[s]) rs2_value = fwd_value[DATA_W*s +: DATA_W];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush || !in_valid)            cnt_d = '0;
    else if (stall || load_dep_stall)  cnt_d = cnt_q;
    else if (cnt_q == last)            cnt_d = '0;
    else                               cnt_d = cnt_q + part_t'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state flops use non-blocking assignment so all registers update together at the edge.
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_clarvi_part_sequencer.sv
// Scoreboard bench: stimulus pushes expected issues, a negedge monitor pops and compares;
// two instances cover NPARTS=2 and NPARTS=4.
module tb_clarvi_part_sequencer;

  localparam logic [31:0] RF1 = 32'h1111_1111;
  localparam logic [31:0] RF2 = 32'h2222_2222;

  typedef struct {
    logic [1:0]  idx;
    logic        first;
    logic        last;
    logic        fh;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];
  int   tests = 0;
  int   failed = 0;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid2, in_valid4, in_single, in_reverse, stall, flush;
  logic [4:0]  rs1, rs2;
  logic        rs1_used, rs2_used;
  logic [31:0] rf_rs1, rf_rs2;
  logic [2:0]  fwd_valid, fwd_is_load;
  logic [14:0] fwd_rd;
  logic [2:0]  fwd_part2;
  logic [5:0]  fwd_part4;
  logic [95:0] fwd_value;
  logic        fwd_load_fault;

  logic        out_valid2, part_first2, part_last2, fetch_hold2, lds2;
  logic [0:0]  part_idx2;
  logic [31:0] rs1_value2, rs2_value2;
  logic        out_valid4, part_first4, part_last4, fetch_hold4, lds4;
  logic [1:0]  part_idx4;
  logic [31:0] rs1_value4, rs2_value4;

  always #5 clock = ~clock;

  clarvi_part_sequencer #(.NPARTS(2), .DATA_W(32), .NFWD(3)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid2), .in_single(in_single),
    .in_reverse(in_reverse), .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load), .fwd_rd(fwd_rd), .fwd_part(fwd_part2),
    .fwd_value(fwd_value), .fwd_load_fault(fwd_load_fault), .out_valid(out_valid2),
    .part_idx(part_idx2), .part_first(part_first2), .part_last(part_last2),
    .fetch_hold(fetch_hold2), .load_dep_stall(lds2), .rs1_value(rs1_value2), .rs2_value(rs2_value2)
  );

  clarvi_part_sequencer #(.NPARTS(4), .DATA_W(32), .NFWD(3)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid4), .in_single(in_single),
    .in_reverse(in_reverse), .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load), .fwd_rd(fwd_rd), .fwd_part(fwd_part4),
    .fwd_value(fwd_value), .fwd_load_fault(fwd_load_fault), .out_valid(out_valid4),
    .part_idx(part_idx4), .part_first(part_first4), .part_last(part_last4),
    .fetch_hold(fetch_hold4), .load_dep_stall(lds4), .rs1_value(rs1_value4), .rs2_value(rs2_value4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] idx, input logic first, input logic last,
                              input logic fh, input logic [31:0] v1, input logic [31:0] v2);
    exp_t e;
    e.idx = idx; e.first = first; e.last = last; e.fh = fh; e.v1 = v1; e.v2 = v2;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every issuing cycle must match the oldest expectation for that instance.
  always @(negedge clock) begin
    if (reset_n && out_valid2) begin
      if (q2.size() == 0) check("dut2 unexpected issue", 64'(part_idx2), 64'hFFFF);
      else begin
        exp_t e;
        e = q2.pop_front();
        check("dut2 part_idx", 64'(part_idx2), 64'(e.idx));
        check("dut2 part_first", 64'(part_first2), 64'(e.first));
        check("dut2 part_last", 64'(part_last2), 64'(e.last));
        check("dut2 fetch_hold", 64'(fetch_hold2), 64'(e.fh));
        check("dut2 rs1_value", 64'(rs1_value2), 64'(e.v1));
        check("dut2 rs2_value", 64'(rs2_value2), 64'(e.v2));
      end
    end
    if (reset_n && out_valid4) begin
      if (q4.size() == 0) check("dut4 unexpected issue", 64'(part_idx4), 64'hFFFF);
      else begin
        exp_t e;
        e = q4.pop_front();
        check("dut4 part_idx", 64'(part_idx4), 64'(e.idx));
        check("dut4 part_first", 64'(part_first4), 64'(e.first));
        check("dut4 part_last", 64'(part_last4), 64'(e.last));
        check("dut4 fetch_hold", 64'(fetch_hold4), 64'(e.fh));
        check("dut4 rs1_value", 64'(rs1_value4), 64'(e.v1));
        check("dut4 rs2_value", 64'(rs2_value4), 64'(e.v2));
      end
    end
  end

  initial begin
    reset_n = 1'b0; in_valid2 = 1'b0; in_valid4 = 1'b0; in_single = 1'b0; in_reverse = 1'b0;
    stall = 1'b0; flush = 1'b0; rs1 = 5'd1; rs2 = 5'd2; rs1_used = 1'b1; rs2_used = 1'b1;
    rf_rs1 = RF1; rf_rs2 = RF2; fwd_valid = '0; fwd_is_load = '0; fwd_rd = '0;
    fwd_part2 = '0; fwd_part4 = '0; fwd_value = '0; fwd_load_fault = 1'b0;

    // Reset state
    #12;
    check("rst out_valid", 64'(out_valid4), 64'd0);
    check("rst fetch_hold", 64'(fetch_hold4), 64'd0);
    check("rst load_dep_stall", 64'(lds4), 64'd0);
    check("rst part_first", 64'(part_first4), 64'd1);
    check("rst part_first dut2", 64'(part_first2), 64'd1);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Two-part forward instruction
    in_valid2 = 1'b1;
    q2.push_back(mk(2'd0, 1'b1, 1'b0, 1'b1, RF1, RF2));
    next_cycle();
    q2.push_back(mk(2'd1, 1'b0, 1'b1, 1'b0, RF1, RF2));
    next_cycle();
    // Single-part instruction
    in_single = 1'b1;
    q2.push_back(mk(2'd0, 1'b1, 1'b1, 1'b0, RF1, RF2));
    next_cycle();
    in_valid2 = 1'b0; in_single = 1'b0;
    next_cycle();

    // Four-part reverse with a one-cycle stall on part 2
    in_valid4 = 1'b1; in_reverse = 1'b1;
    q4.push_back(mk(2'd3, 1'b1, 1'b0, 1'b1, RF1, RF2));
    next_cycle();
    stall = 1'b1;
    #1;
    check("stall part_idx", 64'(part_idx4), 64'd2);
    check("stall out_valid", 64'(out_valid4), 64'd0);
    check("stall fetch_hold", 64'(fetch_hold4), 64'd1);
    next_cycle();
    stall = 1'b0;
    q4.push_back(mk(2'd2, 1'b0, 1'b0, 1'b1, RF1, RF2));
    next_cycle();
    q4.push_back(mk(2'd1, 1'b0, 1'b0, 1'b1, RF1, RF2));
    next_cycle();
    q4.push_back(mk(2'd0, 1'b0, 1'b1, 1'b0, RF1, RF2));
    next_cycle();
    in_reverse = 1'b0;

    // Flush at cnt=1 restarts at part 0
    q4.push_back(mk(2'd0, 1'b1, 1'b0, 1'b1, RF1, RF2));
    next_cycle();
    flush = 1'b1;
    #1;
    check("flush out_valid", 64'(out_valid4), 64'd0);
    check("flush part_idx", 64'(part_idx4), 64'd1);
    next_cycle();
    flush = 1'b0;
    q4.push_back(mk(2'd0, 1'b1, 1'b0, 1'b1, RF1, RF2));
    next_cycle();
    q4.push_back(mk(2'd1, 1'b0, 1'b0, 1'b1, RF1, RF2));
    next_cycle();
    q4.push_back(mk(2'd2, 1'b0, 1'b0, 1'b1, RF1, RF2));
    next_cycle();
    // Asynchronous reset mid-instruction
    check("pre-reset part_idx", 64'(part_idx4), 64'd3);
    in_valid4 = 1'b0; reset_n = 1'b0;
    #1;
    check("async rst part_idx", 64'(part_idx4), 64'd0);
    check("async rst part_first", 64'(part_first4), 64'd1);
    #1 reset_n = 1'b1;
    next_cycle();
    in_valid4 = 1'b1;
    q4.push_back(mk(2'd0, 1'b1, 1'b0, 1'b1, RF1, RF2));
    next_cycle();
    in_valid4 = 1'b0;
    next_cycle();

    // Forwarding priority and eligibility (single-part so part_idx=0)
    in_valid2 = 1'b1; in_single = 1'b1; rs1 = 5'd5; rs2 = 5'd9;
    fwd_valid = 3'b110; fwd_rd = {5'd5, 5'd5, 5'd0}; fwd_part2 = 3'b000;
    fwd_value = {32'h1234_5678, 32'hAAAA_0000, 32'hDEAD_BEEF};
    q2.push_back(mk(2'd0, 1'b1, 1'b1, 1'b0, 32'hAAAA_0000, RF2));
    next_cycle();
    fwd_part2 = 3'b010;
    q2.push_back(mk(2'd0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, RF2));
    next_cycle();
    rs1_used = 1'b0; fwd_valid = 3'b111; fwd_is_load = 3'b001;
    fwd_rd = {5'd5, 5'd5, 5'd5}; fwd_part2 = 3'b000;
    q2.push_back(mk(2'd0, 1'b1, 1'b1, 1'b0, 32'hAAAA_0000, RF2));
    next_cycle();
    rs1_used = 1'b1; fwd_is_load = 3'b000;
    q2.push_back(mk(2'd0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, RF2));
    next_cycle();
    rs1 = 5'd0; fwd_rd = '0;
    q2.push_back(mk(2'd0, 1'b1, 1'b1, 1'b0, RF1, RF2));
    next_cycle();
    rs1 = 5'd3; rs2 = 5'd5; fwd_rd = {5'd5, 5'd5, 5'd5};
    q2.push_back(mk(2'd0, 1'b1, 1'b1, 1'b0, RF1, 32'hDEAD_BEEF));
    next_cycle();
    in_valid2 = 1'b0; in_single = 1'b0; fwd_valid = '0; rs1 = 5'd1; rs2 = 5'd2;
    next_cycle();

    // Load-use hazard on a four-part instruction
    in_valid4 = 1'b1; rs2 = 5'd7;
    fwd_valid = 3'b001; fwd_is_load = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd7}; fwd_part4 = '0;
    #1;
    check("load-use stall", 64'(lds4), 64'd1);
    check("load-use out_valid", 64'(out_valid4), 64'd0);
    check("load-use fetch_hold", 64'(fetch_hold4), 64'd1);
    next_cycle();
    fwd_valid = 3'b000;
    q4.push_back(mk(2'd0, 1'b1, 1'b0, 1'b1, RF1, RF2));
    next_cycle();
    fwd_valid = 3'b001; fwd_part4 = {2'd0, 2'd0, 2'd1}; fwd_load_fault = 1'b1;
    #1;
    check("load fault no stall", 64'(lds4), 64'd0);
    q4.push_back(mk(2'd1, 1'b0, 1'b0, 1'b1, RF1, RF2));
    next_cycle();
    fwd_load_fault = 1'b0; fwd_part4 = {2'd0, 2'd0, 2'd2};
    #1;
    check("load-use stall p2", 64'(lds4), 64'd1);
    next_cycle();
    check("load-use hold idx", 64'(part_idx4), 64'd2);
    fwd_valid = 3'b000;
    q4.push_back(mk(2'd2, 1'b0, 1'b0, 1'b1, RF1, RF2));
    next_cycle();
    q4.push_back(mk(2'd3, 1'b0, 1'b1, 1'b0, RF1, RF2));
    next_cycle();
    in_valid4 = 1'b0; rs2 = 5'd2; fwd_is_load = '0;
    next_cycle();
    next_cycle();

    check("dut2 pending expectations", 64'(q2.size()), 64'd0);
    check("dut4 pending expectations", 64'(q4.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
